sound_sequencer: RTL and testbench

// Upstream control stage for the audio player. Turns one-cycle game events into
// the sound_t selection, a sample-rate strobe and a restart pulse for the player.

---
 rtl/sound_sequencer.sv | 152 +++++++++++++++
 tb/tb_sound_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Audio control stage: maps game events to clip selection, sample strobe
// and restart pulse, timing each clip by sample count.
package sound_pkg;
  typedef enum logic [1:0] {
    SOUND_GAME_PLAY = 2'd0,
    SOUND_READY     = 2'd1,
    SOUND_FAIL      = 2'd2,
    SOUND_WIN       = 2'd3
  } sound_t;
endpackage

module sound_sequencer
  import sound_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int SAMPLE_HZ = 8_000,
  parameter int INTRO_LEN = 12280,
  parameter int CHOMP_LEN = 5736,
  parameter int DEATH_LEN = 33736,
  parameter int WIN_LEN   = 12280,
  parameter int CNT_W     = 16
) (
  input  logic   clk_25MHZ,
  input  logic   rst_n,
  input  logic   ev_start,
  input  logic   ev_chomp,
  input  logic   ev_death,
  input  logic   ev_win,
  output logic   clk_8KHZ,
  output sound_t sound_type,
  output logic   sound_restart,
  output logic   en,
  output logic   busy
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE, INTRO, CHOMP, DEATH, WIN
  } state_t;

  state_t         state, state_nx, ev_state;
  sound_t         sound_nx;
  logic [PW-1:0]  pre;
  logic [CNT_W-1:0] cnt, last;
  logic [2:0]     cur_pri, ev_pri;
  logic           armed, accept, clip_end;

  always_comb begin
    ev_state = IDLE;
    ev_pri   = 3'd0;
    if (ev_death) begin
      ev_state = DEATH;
      ev_pri   = 3'd4;
    end else if (ev_win) begin
      ev_state = WIN;
      ev_pri   = 3'd3;
    end else if (ev_start) begin
      ev_state = INTRO;
      ev_pri   = 3'd2;
    end else if (ev_chomp) begin
      ev_state = CHOMP;
      ev_pri   = 3'd1;
    end
  end

  always_comb begin
    cur_pri = 3'd0;
    last    = '0;
    unique case (state)
      INTRO: begin
        cur_pri = 3'd2;
        last    = CNT_W'(INTRO_LEN - 1);
      end
      CHOMP: begin
        cur_pri = 3'd1;
        last    = CNT_W'(CHOMP_LEN - 1);
      end
      DEATH: begin
        cur_pri = 3'd4;
        last    = CNT_W'(DEATH_LEN - 1);
      end
      WIN: begin
        cur_pri = 3'd3;
        last    = CNT_W'(WIN_LEN - 1);
      end
      default: begin
        cur_pri = 3'd0;
        last    = '0;
      end
    endcase
  end

  // A clip on its final strobe no longer holds its priority.
  assign clip_end = clk_8KHZ && (state != IDLE) && (cnt == last);
  assign accept   = armed && (ev_pri != 3'd0) &&
                    (clip_end || (ev_pri >= cur_pri));

  always_comb begin
    state_nx = state;
    if (accept)
      state_nx = ev_state;
    else if (clip_end)
      state_nx = IDLE;
  end

  always_comb begin
    sound_nx = SOUND_GAME_PLAY;
    unique case (state_nx)
      INTRO:   sound_nx = SOUND_READY;
      DEATH:   sound_nx = SOUND_FAIL;
      WIN:     sound_nx = SOUND_WIN;
      default: sound_nx = SOUND_GAME_PLAY;
    endcase
  end

  always_ff @(posedge clk_25MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      armed         <= 1'b0;
      pre           <= '0;
      clk_8KHZ      <= 1'b0;
      cnt           <= '0;
      sound_type    <= SOUND_GAME_PLAY;
      sound_restart <= 1'b0;
      en            <= 1'b0;
      busy          <= 1'b0;
    end else begin
      armed         <= 1'b1;
      state         <= state_nx;
      sound_type    <= sound_nx;
      sound_restart <= accept;
      en            <= (state_nx != IDLE);
      busy          <= (state_nx != IDLE);
      if (accept) begin
        pre      <= '0;
        clk_8KHZ <= 1'b0;
        cnt      <= '0;
      end else begin
        pre      <= (pre == PRE_TOP) ? '0 : pre + 1'b1;
        clk_8KHZ <= (pre == PRE_TOP);
        if (clip_end)
          cnt <= '0;
        else if (clk_8KHZ && (state != IDLE))
          cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer using a short divider and
// short clip lengths so whole clips fit in a brief run.
module tb_sound_sequencer;
  import sound_pkg::*;

  localparam int DIV   = 5;
  localparam int L_INT = 6;
  localparam int L_CH  = 4;
  localparam int L_DE  = 9;
  localparam int L_WIN = 3;

  logic   clk_25MHZ = 1'b0;
  logic   rst_n     = 1'b0;
  logic   ev_start  = 1'b0;
  logic   ev_chomp  = 1'b0;
  logic   ev_death  = 1'b0;
  logic   ev_win    = 1'b0;
  logic   clk_8KHZ, sound_restart, en, busy;
  sound_t sound_type;

  int errors = 0;
  int checks = 0;

  always #20 clk_25MHZ = ~clk_25MHZ;

  sound_sequencer #(
    .CLK_HZ(40), .SAMPLE_HZ(8),
    .INTRO_LEN(L_INT), .CHOMP_LEN(L_CH),
    .DEATH_LEN(L_DE), .WIN_LEN(L_WIN),
    .CNT_W(8)
  ) dut (
    .clk_25MHZ(clk_25MHZ),
    .rst_n(rst_n),
    .ev_start(ev_start),
    .ev_chomp(ev_chomp),
    .ev_death(ev_death),
    .ev_win(ev_win),
    .clk_8KHZ(clk_8KHZ),
    .sound_type(sound_type),
    .sound_restart(sound_restart),
    .en(en),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_25MHZ);
    #1;
  endtask

  task automatic pulse(input logic s, input logic c,
                       input logic d, input logic w);
    ev_start = s;
    ev_chomp = c;
    ev_death = d;
    ev_win   = w;
    step;
    ev_start = 1'b0;
    ev_chomp = 1'b0;
    ev_death = 1'b0;
    ev_win   = 1'b0;
  endtask

  task automatic run_idle(input int budget, output int strobes,
                          output int cycles);
    strobes = 0;
    cycles  = 0;
    do begin
      step;
      cycles++;
      if (clk_8KHZ) strobes++;
    end while (en && cycles < budget);
  endtask

  task automatic wait_strobes(input int n, input int budget,
                              output int got);
    int c;
    got = 0;
    c   = 0;
    while (got < n && c < budget) begin
      step;
      c++;
      if (clk_8KHZ) got++;
    end
  endtask

  initial begin
    int st, cy, got;
    int last_i, bad_per, bad_wid, bad_en, nstb;
    logic prev;

    #5;
    chk("rst_clk", clk_8KHZ, 0);
    chk("rst_type", sound_type, SOUND_GAME_PLAY);
    chk("rst_restart", sound_restart, 0);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    step;
    step;
    rst_n = 1'b1;

    // first cycle after release: event must be ignored
    pulse(1, 0, 0, 0);
    chk("arm_restart", sound_restart, 0);
    chk("arm_en", en, 0);

    last_i  = -1;
    bad_per = 0;
    bad_wid = 0;
    bad_en  = 0;
    nstb    = 0;
    prev    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step;
      if (clk_8KHZ) begin
        if (prev) bad_wid++;
        if (last_i >= 0 && i - last_i != DIV) bad_per++;
        last_i = i;
        nstb++;
      end
      prev = clk_8KHZ;
      if (en !== 1'b0 || sound_type !== SOUND_GAME_PLAY) bad_en++;
    end
    chk("t1_strobes", nstb, 200 / DIV);
    chk("t1_period", bad_per, 0);
    chk("t1_width", bad_wid, 0);
    chk("t1_idle", bad_en, 0);

    pulse(1, 0, 0, 0);
    chk("t2_restart", sound_restart, 1);
    chk("t2_type", sound_type, SOUND_READY);
    chk("t2_en", en, 1);
    chk("t2_busy", busy, 1);
    run_idle(200, st, cy);
    chk("t2_strobes", st, L_INT);
    chk("t2_cycles", cy, L_INT * DIV + 1);
    chk("t2_type_end", sound_type, SOUND_GAME_PLAY);
    chk("t2_busy_end", busy, 0);

    pulse(0, 1, 0, 0);
    chk("t3_restart1", sound_restart, 1);
    chk("t3_type", sound_type, SOUND_GAME_PLAY);
    chk("t3_en", en, 1);
    wait_strobes(2, 100, got);
    chk("t3_wait", got, 2);
    pulse(0, 1, 0, 0);
    chk("t3_restart2", sound_restart, 1);
    run_idle(200, st, cy);
    chk("t3_strobes", st, L_CH);
    chk("t3_cycles", cy, L_CH * DIV + 1);

    pulse(0, 1, 0, 0);
    step;
    step;
    pulse(0, 0, 1, 0);
    chk("t4_death_restart", sound_restart, 1);
    chk("t4_death_type", sound_type, SOUND_FAIL);
    step;
    step;
    pulse(0, 1, 0, 0);
    chk("t4_drop_restart", sound_restart, 0);
    chk("t4_drop_type", sound_type, SOUND_FAIL);
    chk("t4_drop_en", en, 1);
    run_idle(200, st, cy);
    chk("t4_end_en", en, 0);

    pulse(0, 1, 0, 1);
    chk("t5_win_type", sound_type, SOUND_WIN);
    chk("t5_win_restart", sound_restart, 1);
    run_idle(200, st, cy);
    chk("t5_win_strobes", st, L_WIN);

    pulse(1, 0, 0, 0);
    wait_strobes(L_INT, 200, got);
    chk("t5_intro_wait", got, L_INT);
    pulse(0, 1, 0, 0);
    chk("t5_chain_en", en, 1);
    chk("t5_chain_type", sound_type, SOUND_GAME_PLAY);
    chk("t5_chain_restart", sound_restart, 1);
    run_idle(200, st, cy);
    chk("t5_chain_strobes", st, L_CH);
    chk("t5_chain_cycles", cy, L_CH * DIV + 1);

    pulse(0, 0, 1, 0);
    step;
    step;
    step;
    #5;
    rst_n = 1'b0;
    #1;
    chk("t6_en", en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_type", sound_type, SOUND_GAME_PLAY);
    chk("t6_clk", clk_8KHZ, 0);
    chk("t6_restart", sound_restart, 0);
    step;
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (sound_restart !== 1'b0 || en !== 1'b0) got++;
    end
    chk("t6_after_release", got, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
